// File: rtl/butterfly_array_pipe.sv
// Pipelined array of LANES modular butterflies over Z_Q (NTT / INTT / pointwise-multiply / add-sub).
// Mode, halving flag and tag ride along with each beat; a single global stall freezes every stage.
module butterfly_array_pipe #(
    parameter int LANES      = 4,
    parameter int W          = 12,
    parameter int Q          = 3329,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic                 in_half,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic [LANES*W-1:0]   in_w,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_a,
    output logic [LANES*W-1:0]   out_b,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam logic [1:0]       MODE_NTT    = 2'd0;
    localparam logic [1:0]       MODE_INTT   = 2'd1;
    localparam logic [1:0]       MODE_PWM    = 2'd2;
    localparam logic [1:0]       MODE_ADDSUB = 2'd3;
    localparam logic [W:0]       QW          = (W+1)'(Q);
    localparam logic [2*W-1:0]   QP          = (2*W)'(Q);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QW) begin
            s = s - QW;
        end else begin
            s = s;
        end
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + QW - {1'b0, y};
        if (s >= QW) begin
            s = s - QW;
        end else begin
            s = s;
        end
        return s[W-1:0];
    endfunction

    // Exact reduction of the full 2W-bit product; the divisor is a constant.
    function automatic logic [W-1:0] mod_red(input logic [2*W-1:0] x);
        logic [2*W-1:0] m;
        m = x % QP;
        return m[W-1:0];
    endfunction

    // Multiply by 2^-1 mod Q: odd values borrow one Q so the shift is exact.
    function automatic logic [W-1:0] halve(input logic [W-1:0] x);
        logic [W:0] s;
        if (x[0]) begin
            s = {1'b0, x} + QW;
        end else begin
            s = {1'b0, x};
        end
        return s[W:1];
    endfunction

    function automatic logic [2*W-1:0] pre_lane(input logic [1:0] mode, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] w);
        logic [W-1:0] x;
        logic [W-1:0] y;
        case (mode)
            MODE_NTT:    begin x = b;             y = w;    end
            MODE_INTT:   begin x = mod_sub(a, b); y = w;    end
            MODE_PWM:    begin x = a;             y = b;    end
            MODE_ADDSUB: begin x = '0;            y = '0;   end
            default:     begin x = '0;            y = '0;   end
        endcase
        return {x, y};
    endfunction

    function automatic logic [2*W-1:0] post_lane(input logic [1:0] mode, input logic half,
                                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [2*W-1:0] prod);
        logic [W-1:0] p;
        logic [W-1:0] oa;
        logic [W-1:0] ob;
        p = mod_red(prod);
        case (mode)
            MODE_NTT:    begin oa = mod_add(a, p); ob = mod_sub(a, p); end
            MODE_INTT:   begin oa = mod_add(a, b); ob = p;             end
            MODE_PWM:    begin oa = p;             ob = mod_add(a, b); end
            MODE_ADDSUB: begin oa = mod_add(a, b); ob = mod_sub(a, b); end
            default:     begin oa = mod_add(a, b); ob = mod_sub(a, b); end
        endcase
        if (half) begin
            oa = halve(oa);
            ob = halve(ob);
        end else begin
            oa = oa;
            ob = ob;
        end
        return {oa, ob};
    endfunction

    logic                                          stall_s;

    logic                                          s1_valid_q;
    logic [1:0]                                    s1_mode_q;
    logic                                          s1_half_q;
    logic [TAG_W-1:0]                              s1_tag_q;
    logic [LANES-1:0][W-1:0]                       s1_a_q, s1_b_q, s1_x_q, s1_y_q;
    logic [LANES-1:0][W-1:0]                       s1_x_d, s1_y_d;

    logic [MUL_STAGES-1:0]                         m_valid_q;
    logic [MUL_STAGES-1:0][1:0]                    m_mode_q;
    logic [MUL_STAGES-1:0]                         m_half_q;
    logic [MUL_STAGES-1:0][TAG_W-1:0]              m_tag_q;
    logic [MUL_STAGES-1:0][LANES-1:0][W-1:0]       m_a_q, m_b_q;
    logic [MUL_STAGES-1:0][LANES-1:0][2*W-1:0]     m_p_q;
    logic [LANES-1:0][2*W-1:0]                     prod_d;

    logic                                          out_valid_q;
    logic [LANES-1:0][W-1:0]                       out_a_q, out_b_q, out_a_d, out_b_d;
    logic [TAG_W-1:0]                              out_tag_q;

    assign stall_s   = out_valid_q && !out_ready;
    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_tag   = out_tag_q;
    assign busy      = s1_valid_q | (|m_valid_q) | out_valid_q;

    // Select multiplier operands per lane from the incoming beat.
    always_comb begin
        s1_x_d = '0;
        s1_y_d = '0;
        for (int i = 0; i < LANES; i++) begin
            {s1_x_d[i], s1_y_d[i]} = pre_lane(in_mode, in_a[i*W +: W], in_b[i*W +: W], in_w[i*W +: W]);
        end
    end

    // Full-width lane products entering the multiply pipeline.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = (2*W)'(s1_x_q[i]) * (2*W)'(s1_y_q[i]);
        end
    end

    // Reduce the product, then post add/sub and optional halving per lane.
    always_comb begin
        out_a_d = '0;
        out_b_d = '0;
        for (int i = 0; i < LANES; i++) begin
            {out_a_d[i], out_b_d[i]} = post_lane(m_mode_q[MUL_STAGES-1], m_half_q[MUL_STAGES-1],
                                                 m_a_q[MUL_STAGES-1][i], m_b_q[MUL_STAGES-1][i],
                                                 m_p_q[MUL_STAGES-1][i]);
        end
    end

    // Pipeline advance: every stage shifts together unless the output is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 2'd0;
            s1_half_q   <= 1'b0;
            s1_tag_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            m_valid_q   <= '0;
            m_mode_q    <= '0;
            m_half_q    <= '0;
            m_tag_q     <= '0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            m_p_q       <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_tag_q   <= '0;
        end else if (!stall_s) begin
            s1_valid_q  <= in_valid;
            s1_mode_q   <= in_mode;
            s1_half_q   <= in_half;
            s1_tag_q    <= in_tag;
            s1_a_q      <= in_a;
            s1_b_q      <= in_b;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            m_valid_q[0] <= s1_valid_q;
            m_mode_q[0]  <= s1_mode_q;
            m_half_q[0]  <= s1_half_q;
            m_tag_q[0]   <= s1_tag_q;
            m_a_q[0]     <= s1_a_q;
            m_b_q[0]     <= s1_b_q;
            m_p_q[0]     <= prod_d;
            for (int k = 1; k < MUL_STAGES; k++) begin
                m_valid_q[k] <= m_valid_q[k-1];
                m_mode_q[k]  <= m_mode_q[k-1];
                m_half_q[k]  <= m_half_q[k-1];
                m_tag_q[k]   <= m_tag_q[k-1];
                m_a_q[k]     <= m_a_q[k-1];
                m_b_q[k]     <= m_b_q[k-1];
                m_p_q[k]     <= m_p_q[k-1];
            end
            out_valid_q <= m_valid_q[MUL_STAGES-1];
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_tag_q   <= m_tag_q[MUL_STAGES-1];
        end
    end

endmodule
